// File: rtl/pc_gen_if.sv
// pc_gen_if -- fetch-control bundle between the pipeline and the PC generator.
//   stall         : pipeline stall vector (only bit 0 matters to pc_gen)
//   branch_flag   : redirect request, branch_target valid with it
//   flush         : exception/flush redirect, new_pc valid with it
//   pc            : registered fetch address
//   ce            : registered instruction-memory chip enable
//   br_pending    : a branch captured during stall is waiting to be applied
//   misalign      : pc low log2(STEP) bits are nonzero
// The pipeline side uses modport master; pc_gen uses modport slave.
interface pc_gen_if #(
    parameter int ADDR_W  = 32,
    parameter int STALL_W = 6
);
    logic [STALL_W-1:0] stall;
    logic               branch_flag;
    logic [ADDR_W-1:0]  branch_target;
    logic               flush;
    logic [ADDR_W-1:0]  new_pc;
    logic [ADDR_W-1:0]  pc;
    logic               ce;
    logic               br_pending;
    logic               misalign;

    modport master (
        output stall, branch_flag, branch_target, flush, new_pc,
        input  pc, ce, br_pending, misalign
    );

    modport slave (
        input  stall, branch_flag, branch_target, flush, new_pc,
        output pc, ce, br_pending, misalign
    );
endinterface

// File: rtl/pc_gen.sv
// pc_gen -- instruction fetch address generator.
//   clk : clock, all state changes on the rising edge
//   rst : synchronous active-high reset
//   bus : pc_gen_if.slave (stall/branch/flush in, pc/ce/br_pending/misalign out)
// Per edge with ce=1 the priority is: flush, then an unstalled live or pending
// branch, then stall hold, then pc+STEP. A branch seen while stalled is parked
// in a one-entry pending register and applied on the first unstalled edge.
module pc_gen #(
    parameter int                ADDR_W       = 32,
    parameter int                STALL_W      = 6,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(32'h0000_0000),
    parameter int                STEP         = 4
) (
    input logic     clk,
    input logic     rst,
    pc_gen_if.slave bus
);
    // STEP is a power of two, so STEP-1 masks exactly the alignment bits.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(STEP - 1);
    localparam logic [ADDR_W-1:0] STEP_INC   = ADDR_W'(STEP);

    logic [ADDR_W-1:0] pc_q,  pc_d;
    logic              ce_q,  ce_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] tgt_q, tgt_d;
    logic              mis_q, mis_d;

    // Only stall[0] holds fetch; the upper bits belong to later stages.
    logic unused_stall;
    assign unused_stall = ^bus.stall;

    always_ff @(posedge clk) begin
        pc_q   <= pc_d;
        ce_q   <= ce_d;
        pend_q <= pend_d;
        tgt_q  <= tgt_d;
        mis_q  <= mis_d;
    end

    always_comb begin
        pc_d   = pc_q;
        ce_d   = 1'b1;
        pend_d = pend_q;
        tgt_d  = tgt_q;
        if (rst) begin
            ce_d   = 1'b0;
            pend_d = 1'b0;
            tgt_d  = '0;
            pc_d   = RESET_VECTOR;
        end else if (!ce_q) begin
            // First edge out of reset: start fetching at the reset vector.
            pc_d = RESET_VECTOR;
        end else if (bus.flush) begin
            pc_d   = bus.new_pc;
            pend_d = 1'b0;
        end else if (!bus.stall[0]) begin
            if (bus.branch_flag) begin
                pc_d   = bus.branch_target;
                pend_d = 1'b0;
            end else if (pend_q) begin
                pc_d   = tgt_q;
                pend_d = 1'b0;
            end else begin
                pc_d = pc_q + STEP_INC;
            end
        end else if (bus.branch_flag) begin
            // Stalled: park the target; a newer branch replaces an older one.
            pend_d = 1'b1;
            tgt_d  = bus.branch_target;
        end
        mis_d = !rst && ((pc_d & ALIGN_MASK) != '0);
    end

    assign bus.pc         = pc_q;
    assign bus.ce         = ce_q;
    assign bus.br_pending = pend_q;
    assign bus.misalign   = mis_q;
endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;
    localparam logic [31:0] RV = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    pc_gen_if #(.ADDR_W(32), .STALL_W(6)) bus ();

    pc_gen #(.ADDR_W(32), .STALL_W(6), .RESET_VECTOR(RV), .STEP(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // reference model state
    logic [31:0] m_pc;
    logic        m_known;
    logic        m_ce;
    logic        m_pv;
    logic [31:0] m_pt;
    logic        m_mis;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst               = 1'b0;
        bus.stall         = '0;
        bus.branch_flag   = 1'b0;
        bus.branch_target = '0;
        bus.flush         = 1'b0;
        bus.new_pc        = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (bus.ce !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_ce cyc%0d got %b want 0", i, bus.ce);
            end
        end
        n_tests++;
        if (bus.pc !== RV || bus.br_pending !== 1'b0 || bus.misalign !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state pc=%h pend=%b mis=%b want pc=%h pend=0 mis=0",
                     bus.pc, bus.br_pending, bus.misalign, RV);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++;
            if (bus.ce !== 1'b1 || bus.pc !== RV + 32'(4 * i)) begin
                n_fail++;
                $display("FAIL reset_release cyc%0d ce=%b pc=%h want ce=1 pc=%h",
                         i, bus.ce, bus.pc, RV + 32'(4 * i));
            end
        end
    endtask

    task automatic test_stalled_branch();
        idle_inputs();
        bus.flush = 1'b1; bus.new_pc = 32'h10;
        tick();
        bus.flush = 1'b0;
        bus.stall = 6'b000001;
        bus.branch_flag = 1'b1; bus.branch_target = 32'h200;
        for (int i = 0; i < 3; i++) begin
            tick();
            bus.branch_flag = 1'b0;
            n_tests++;
            if (bus.pc !== 32'h10 || bus.br_pending !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_hold cyc%0d pc=%h pend=%b want pc=10 pend=1",
                         i, bus.pc, bus.br_pending);
            end
        end
        bus.stall = '0;
        tick();
        n_tests++;
        if (bus.pc !== 32'h200 || bus.br_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL pending_apply pc=%h pend=%b want pc=200 pend=0", bus.pc, bus.br_pending);
        end
        tick();
        n_tests++;
        if (bus.pc !== 32'h204) begin
            n_fail++;
            $display("FAIL after_pending pc=%h want 204", bus.pc);
        end
    endtask

    task automatic test_flush_priority();
        idle_inputs();
        bus.stall = 6'b000001;
        bus.branch_flag = 1'b1; bus.branch_target = 32'h300;
        bus.flush = 1'b1; bus.new_pc = 32'h8000_0180;
        tick();
        idle_inputs();
        n_tests++;
        if (bus.pc !== 32'h8000_0180 || bus.br_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_priority pc=%h pend=%b want pc=80000180 pend=0",
                     bus.pc, bus.br_pending);
        end
    endtask

    task automatic test_wrap();
        idle_inputs();
        bus.flush = 1'b1; bus.new_pc = 32'hFFFF_FFFC;
        tick();
        bus.flush = 1'b0;
        tick();
        n_tests++;
        if (bus.pc !== 32'h0 || bus.misalign !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap pc=%h mis=%b want pc=0 mis=0", bus.pc, bus.misalign);
        end
    endtask

    task automatic test_misalign();
        idle_inputs();
        bus.branch_flag = 1'b1; bus.branch_target = 32'h102;
        tick();
        bus.branch_flag = 1'b0;
        n_tests++;
        if (bus.pc !== 32'h102 || bus.misalign !== 1'b1) begin
            n_fail++;
            $display("FAIL misalign_load pc=%h mis=%b want pc=102 mis=1", bus.pc, bus.misalign);
        end
        tick();
        n_tests++;
        if (bus.pc !== 32'h106 || bus.misalign !== 1'b1) begin
            n_fail++;
            $display("FAIL misalign_inc pc=%h mis=%b want pc=106 mis=1", bus.pc, bus.misalign);
        end
        bus.flush = 1'b1; bus.new_pc = 32'h400;
        tick();
        bus.flush = 1'b0;
        n_tests++;
        if (bus.pc !== 32'h400 || bus.misalign !== 1'b0) begin
            n_fail++;
            $display("FAIL misalign_clear pc=%h mis=%b want pc=400 mis=0", bus.pc, bus.misalign);
        end
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        bus.stall = 6'b111111;
        bus.branch_flag = 1'b1; bus.branch_target = 32'h500;
        tick();
        bus.branch_flag = 1'b0;
        n_tests++;
        if (bus.br_pending !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_setup pend=%b want 1", bus.br_pending);
        end
        rst = 1'b1;
        tick();
        bus.stall = '0;
        n_tests++;
        if (bus.ce !== 1'b0 || bus.br_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_assert ce=%b pend=%b want ce=0 pend=0", bus.ce, bus.br_pending);
        end
        rst = 1'b0;
        tick();
        n_tests++;
        if (bus.ce !== 1'b1 || bus.pc !== RV || bus.br_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_release ce=%b pc=%h pend=%b want ce=1 pc=%h pend=0",
                     bus.ce, bus.pc, bus.br_pending, RV);
        end
        tick();
        n_tests++;
        if (bus.pc !== RV + 32'd4) begin
            n_fail++;
            $display("FAIL midrst_no_pending pc=%h want %h", bus.pc, RV + 32'd4);
        end
    endtask

    // Applies the fetch rules for one edge to the model.
    task automatic model_edge(input logic r, input logic [5:0] st, input logic bf,
                              input logic [31:0] bt, input logic fl, input logic [31:0] np);
        if (r) begin
            if (!m_ce) begin
                m_pc = RV; m_known = 1'b1;
            end else begin
                m_known = 1'b0;
            end
            m_ce = 1'b0; m_pv = 1'b0; m_pt = '0; m_mis = 1'b0;
            return;
        end
        if (!m_ce) begin
            m_pc = RV; m_known = 1'b1; m_ce = 1'b1;
        end else if (fl) begin
            m_pc = np; m_known = 1'b1; m_pv = 1'b0;
        end else if (st[0] == 1'b0 && bf) begin
            m_pc = bt; m_known = 1'b1; m_pv = 1'b0;
        end else if (st[0] == 1'b0 && m_pv) begin
            m_pc = m_pt; m_known = 1'b1; m_pv = 1'b0;
        end else if (st[0] == 1'b1) begin
            if (bf) begin
                m_pv = 1'b1; m_pt = bt;
            end
        end else begin
            m_pc = 32'((64'(m_pc) + 64'd4) % 64'h1_0000_0000);
        end
        m_mis = (m_pc % 4) != 0;
    endtask

    task automatic test_random();
        logic [31:0] t;
        logic [31:0] n;
        m_ce = 1'b1; m_known = 1'b0; m_pv = 1'b0; m_pt = '0; m_mis = 1'b0; m_pc = '0;
        idle_inputs();
        rst = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (i > 1) rst = ($urandom_range(0, 199) == 0);
            bus.stall       = 6'($urandom);
            bus.branch_flag = ($urandom_range(0, 4) == 0);
            bus.flush       = ($urandom_range(0, 15) == 0);
            t = $urandom; n = $urandom;
            if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
            if ($urandom_range(0, 3) != 0) n[1:0] = 2'b00;
            if ($urandom_range(0, 31) == 0) n = 32'hFFFF_FFF8;
            bus.branch_target = t;
            bus.new_pc        = n;
            model_edge(rst, bus.stall, bus.branch_flag, t, bus.flush, n);
            tick();
            n_tests++;
            if (bus.ce !== m_ce || bus.br_pending !== m_pv) begin
                n_fail++;
                $display("FAIL rand_ctrl cyc%0d ce=%b pend=%b want ce=%b pend=%b",
                         i, bus.ce, bus.br_pending, m_ce, m_pv);
            end
            if (m_known) begin
                n_tests++;
                if (bus.pc !== m_pc || bus.misalign !== m_mis) begin
                    n_fail++;
                    $display("FAIL rand_pc cyc%0d pc=%h mis=%b want pc=%h mis=%b",
                             i, bus.pc, bus.misalign, m_pc, m_mis);
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_stalled_branch();
        test_flush_priority();
        test_wrap();
        test_misalign();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
